// File: rtl/msp_trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msp_trace_pkg : state codes, record field widths, record packing.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package msp_trace_pkg;

  localparam logic [1:0] c_st_idle   = 2'b00;
  localparam logic [1:0] c_st_run    = 2'b01;
  localparam logic [1:0] c_st_post   = 2'b10;
  localparam logic [1:0] c_st_frozen = 2'b11;

  localparam int c_op_w     = 16;
  localparam int c_irqn_w   = 4;
  localparam int c_meta_w   = c_op_w + 1 + c_irqn_w;
  localparam int c_pc_max_w = 32;
  localparam int c_cyc_max_w = 32;
  localparam int c_rec_max_w = c_pc_max_w + c_meta_w + c_cyc_max_w;

  // Packs {pc, op, irq, irq_num, cyc} into the low bits; callers pass
  // zero-extended pc/cyc and truncate the result to their record width.
  function automatic logic [c_rec_max_w-1:0] rec_pack(
    input logic [c_pc_max_w-1:0]  pc,
    input logic [c_op_w-1:0]      op,
    input logic                   irq,
    input logic [c_irqn_w-1:0]    irq_num,
    input logic [c_cyc_max_w-1:0] cyc,
    input int                     cyc_w
  );
    logic [c_rec_max_w-1:0] r;
    r = c_rec_max_w'(cyc);
    r = r | (c_rec_max_w'({op, irq, irq_num}) << cyc_w);
    r = r | (c_rec_max_w'(pc) << (cyc_w + c_meta_w));
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msp_trace_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msp_trace_ram : DEPTH x WIDTH register array, sync write, async read.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module msp_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             mclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge mclk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/msp_trace.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | msp_trace : instruction-trace recorder, circular buffer, PC trigger. |
// | Optional IRQ trigger: define MSP_TRACE_IRQ_TRIG_EN.     Rev 1.0      |
// +----------------------------------------------------------------------+
module msp_trace
  import msp_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 16,
  parameter int CYC_W     = 8,
  parameter int CNT_W     = 32,
  parameter int POST_TRIG = 4
) (
  input  logic                    mclk,
  input  logic                    puc_rst_n,
  input  logic                    decode,
  input  logic [15:0]             ir,
  input  logic [PC_W-1:0]         pc,
  input  logic                    irq_detect,
  input  logic [3:0]              irq_num,
  input  logic                    arm,
  input  logic                    clr,
  input  logic                    trig_en,
  input  logic [PC_W-1:0]         trig_pc,
`ifdef MSP_TRACE_IRQ_TRIG_EN
  input  logic [3:0]              trig_irq,
`endif
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [PC_W-1:0]         rd_pc,
  output logic [15:0]             rd_op,
  output logic                    rd_irq,
  output logic [3:0]              rd_irq_num,
  output logic [CYC_W-1:0]        rd_cyc,
  output logic                    rd_last,
  output logic [1:0]              trc_state,
  output logic [$clog2(DEPTH):0]  fill,
  output logic [CNT_W-1:0]        inst_number
);

  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int REC_W = PC_W + c_meta_w + CYC_W;
  localparam logic [FW-1:0] c_depth     = FW'(DEPTH);
  localparam logic [AW-1:0] c_post_last = AW'(POST_TRIG - 1);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pend_pc;
  logic [15:0]      r_pend_op;
  logic             r_pend_irq;
  logic [3:0]       r_pend_irqn;
  logic             r_pend_v;
  logic [CYC_W-1:0] r_cyc;
  logic [AW-1:0]    r_wr_ptr;
  logic [FW-1:0]    r_fill;
  logic [AW-1:0]    r_post_cnt;
  logic [FW-1:0]    r_rd_cnt;
  logic [CNT_W-1:0] r_inst;

  logic             w_commit, w_we, w_trig, w_accept, w_rd_valid, w_rd_last;
  logic [AW-1:0]    w_rd_base, w_rd_ptr;
  logic [REC_W-1:0] w_wdata, w_rdata;

  assign w_commit = decode & r_pend_v;
  assign w_we     = w_commit & ~clr & ((r_state == c_st_run) | (r_state == c_st_post));

`ifdef MSP_TRACE_IRQ_TRIG_EN
  assign w_trig = trig_en & ((r_pend_pc == trig_pc) |
                             (r_pend_irq & (r_pend_irqn == trig_irq)));
`else
  assign w_trig = trig_en & (r_pend_pc == trig_pc);
`endif

  assign w_wdata = REC_W'(rec_pack(c_pc_max_w'(r_pend_pc), r_pend_op, r_pend_irq,
                                   r_pend_irqn, c_cyc_max_w'(r_cyc), CYC_W));

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign w_rd_base  = (r_fill == c_depth) ? r_wr_ptr : '0;
  assign w_rd_ptr   = w_rd_base + r_rd_cnt[AW-1:0];
  assign w_rd_valid = (r_state == c_st_frozen) && (r_rd_cnt < r_fill);
  assign w_rd_last  = w_rd_valid && (r_rd_cnt == r_fill - FW'(1));
  assign w_accept   = w_rd_valid & rd_ready;

  msp_trace_ram #(.DEPTH(DEPTH), .WIDTH(REC_W), .AW(AW)) u_ram (
    .mclk  (mclk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .raddr (w_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_pend_pc   <= '0;
      r_pend_op   <= '0;
      r_pend_irq  <= 1'b0;
      r_pend_irqn <= '0;
      r_pend_v    <= 1'b0;
      r_cyc       <= '0;
      r_inst      <= '0;
    end else begin
      if (decode) begin
        r_pend_pc   <= pc;
        r_pend_op   <= ir;
        r_pend_irq  <= irq_detect;
        r_pend_irqn <= irq_num;
        r_cyc       <= CYC_W'(1);
        r_inst      <= r_inst + 1'b1;
      end else if (r_cyc != '1) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (clr || (arm && r_state == c_st_idle)) r_pend_v <= 1'b0;
      else if (decode)                          r_pend_v <= 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_state    <= c_st_idle;
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_rd_cnt   <= '0;
    end else if (clr) begin
      r_state    <= c_st_idle;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_rd_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (arm) begin
            r_state    <= c_st_run;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_rd_cnt   <= '0;
          end
        end
        c_st_run, c_st_post: begin
          if (w_we) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != c_depth) r_fill <= r_fill + 1'b1;
            if (r_state == c_st_run) begin
              if (w_trig) r_state <= (POST_TRIG == 0) ? c_st_frozen : c_st_post;
            end else begin
              r_post_cnt <= r_post_cnt + 1'b1;
              if (r_post_cnt == c_post_last) r_state <= c_st_frozen;
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_last) begin
              r_state  <= c_st_idle;
              r_fill   <= '0;
              r_rd_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  assign rd_valid    = w_rd_valid;
  assign rd_last     = w_rd_last;
  assign rd_pc       = w_rd_valid ? w_rdata[REC_W-1 -: PC_W]            : '0;
  assign rd_op       = w_rd_valid ? w_rdata[CYC_W + 5 +: 16]            : '0;
  assign rd_irq      = w_rd_valid ? w_rdata[CYC_W + 4]                  : 1'b0;
  assign rd_irq_num  = w_rd_valid ? w_rdata[CYC_W +: 4]                 : '0;
  assign rd_cyc      = w_rd_valid ? w_rdata[CYC_W-1:0]                  : '0;
  assign trc_state   = r_state;
  assign fill        = r_fill;
  assign inst_number = r_inst;

endmodule
`default_nettype wire
